// File: rtl/pe_nic.sv
// Network interface between a processing element and one mesh router PE port.
// TX FIFO injects into the router honouring VC polarity; RX FIFO buffers ejected packets for PE reads.
module pe_nic #(
  parameter int DATA_W   = 64,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nic_en,
  input  logic              nic_wr_en,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] nic_di,
  output logic [DATA_W-1:0] nic_do,
  input  logic              net_polarity,
  input  logic              net_ri,
  output logic              net_so,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_ro
);

  localparam int TXA  = $clog2(TX_DEPTH);
  localparam int RXA  = $clog2(RX_DEPTH);
  localparam int TXCW = TXA + 1;
  localparam int RXCW = RXA + 1;

  localparam logic [1:0] ADDR_RX_DATA = 2'b00;
  localparam logic [1:0] ADDR_RX_STAT = 2'b01;
  localparam logic [1:0] ADDR_TX_DATA = 2'b10;
  localparam logic [1:0] ADDR_TX_STAT = 2'b11;

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [TXA-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXCW-1:0]   tx_cnt_q, tx_cnt_d;

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [RXA-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXCW-1:0]   rx_cnt_q, rx_cnt_d;
  logic              rx_ovf_q, rx_ovf_d;

  logic              net_so_q, net_so_d;
  logic [DATA_W-1:0] net_do_q, net_do_d;
  logic [DATA_W-1:0] nic_do_q, nic_do_d;

  logic              txFull, txEmpty, txPush, txPop;
  logic              rxFull, rxEmpty, rxPush, rxPop, peRead;
  logic [DATA_W-1:0] txHead, rxHead, txStatus, rxStatus;

  assign txFull  = (tx_cnt_q == TXCW'(TX_DEPTH));
  assign txEmpty = (tx_cnt_q == '0);
  assign rxFull  = (rx_cnt_q == RXCW'(RX_DEPTH));
  assign rxEmpty = (rx_cnt_q == '0);
  assign txHead  = tx_mem_q[tx_rd_q];
  assign rxHead  = rx_mem_q[rx_rd_q];

  assign txPush = nic_en & nic_wr_en & (addr == ADDR_TX_DATA) & ~txFull;
  // The head may only leave on a matching VC; a mismatch stalls the whole queue.
  assign txPop  = ~txEmpty & net_ri & (txHead[DATA_W-1] == net_polarity);

  assign peRead = nic_en & ~nic_wr_en;
  assign rxPush = net_si & ~rxFull;
  assign rxPop  = peRead & (addr == ADDR_RX_DATA) & ~rxEmpty;

  assign net_ro = ~rxFull;
  assign net_so = net_so_q;
  assign net_do = net_do_q;
  assign nic_do = nic_do_q;

  always_comb begin
    txStatus      = '0;
    txStatus[9:2] = 8'(tx_cnt_q);
    txStatus[1]   = txEmpty;
    txStatus[0]   = txFull;
    rxStatus             = '0;
    rxStatus[DATA_W-1]   = rx_ovf_q;
    rxStatus[9:2]        = 8'(rx_cnt_q);
    rxStatus[1]          = rxEmpty;
    rxStatus[0]          = rxFull;
  end

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    net_so_d = txPop;
    net_do_d = net_do_q;
    if (txPush) tx_wr_d = tx_wr_q + 1'b1;
    if (txPop) begin
      tx_rd_d  = tx_rd_q + 1'b1;
      net_do_d = txHead;
    end
    if (txPush && !txPop) tx_cnt_d = tx_cnt_q + 1'b1;
    else if (!txPush && txPop) tx_cnt_d = tx_cnt_q - 1'b1;
  end

  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    rx_ovf_d = rx_ovf_q;
    nic_do_d = nic_do_q;
    if (rxPush) rx_wr_d = rx_wr_q + 1'b1;
    if (rxPop) rx_rd_d = rx_rd_q + 1'b1;
    if (rxPush && !rxPop) rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!rxPush && rxPop) rx_cnt_d = rx_cnt_q - 1'b1;
    // A new protocol error outranks a simultaneous clear so it is never lost.
    if (net_si && rxFull) rx_ovf_d = 1'b1;
    else if (nic_en && nic_wr_en && addr == ADDR_RX_STAT && nic_di[0]) rx_ovf_d = 1'b0;
    if (peRead) begin
      case (addr)
        ADDR_RX_DATA: nic_do_d = rxEmpty ? '0 : rxHead;
        ADDR_RX_STAT: nic_do_d = rxStatus;
        ADDR_TX_DATA: nic_do_d = '0;
        ADDR_TX_STAT: nic_do_d = txStatus;
        default:      nic_do_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (txPush) tx_mem_q[tx_wr_q] <= nic_di;
    if (rxPush) rx_mem_q[rx_wr_q] <= net_di;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovf_q <= 1'b0;
      net_so_q <= 1'b0;
      net_do_q <= '0;
      nic_do_q <= '0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      rx_ovf_q <= rx_ovf_d;
      net_so_q <= net_so_d;
      net_do_q <= net_do_d;
      nic_do_q <= nic_do_d;
    end
  end

endmodule
